// File: rtl/uart_rx_if.sv
// FIFO write-port bundle between the UART receiver (master) and the async FIFO (slave).
// The receiver drives data/wr_en; the FIFO returns its full flag.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 wr_en;
  logic                 full;

  modport master (output data, output wr_en, input full);
  modport slave  (input data, input wr_en, output full);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver in the FIFO write-clock domain: oversampled, mid-bit sampling,
// one-cycle write strobe gated by full, plus framing/overrun status pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic       wr_clk,
  input  logic       rst,
  input  logic       rx,
  uart_rx_if.master  fifo,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  logic                 rx_meta_r;
  logic                 rx_sync_r;
  state_t               state_r;
  state_t               state_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_s;
  logic [IDX_W-1:0]     idx_r;
  logic [IDX_W-1:0]     idx_s;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_s;
  logic [DATA_BITS-1:0] data_r;
  logic [DATA_BITS-1:0] data_s;
  logic                 wr_en_r;
  logic                 wr_en_s;
  logic                 frame_err_r;
  logic                 frame_err_s;
  logic                 overrun_r;
  logic                 overrun_s;
  logic                 busy_r;

  assign fifo.data  = data_r;
  assign fifo.wr_en = wr_en_r;
  assign busy       = busy_r;
  assign frame_err  = frame_err_r;
  assign overrun    = overrun_r;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      idx_r       <= IDX_ZERO;
      shift_r     <= {DATA_BITS{1'b0}};
      data_r      <= {DATA_BITS{1'b0}};
      wr_en_r     <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      idx_r       <= idx_s;
      shift_r     <= shift_s;
      data_r      <= data_s;
      wr_en_r     <= wr_en_s;
      frame_err_r <= frame_err_s;
      overrun_r   <= overrun_s;
      busy_r      <= (state_s != IDLE);
    end
  end

  // Next-state and output decode; pulses default low so they last one cycle.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    idx_s       = idx_r;
    shift_s     = shift_r;
    data_s      = data_r;
    wr_en_s     = 1'b0;
    frame_err_s = 1'b0;
    overrun_s   = 1'b0;

    case (state_r)
      IDLE: begin
        if (rx_sync_r == 1'b0) begin
          state_s = START;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = IDLE;
        end
      end

      START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_s = CNT_ZERO;
          idx_s = IDX_ZERO;
          if (rx_sync_r == 1'b0) begin
            state_s = DATA;
          end else begin
            state_s = IDLE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      DATA: begin
        if (cnt_r == BIT_LAST) begin
          cnt_s   = CNT_ZERO;
          shift_s = {rx_sync_r, shift_r[DATA_BITS-1:1]};
          if (idx_r == IDX_LAST) begin
            idx_s   = IDX_ZERO;
            state_s = STOP;
          end else begin
            idx_s = idx_r + IDX_ONE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      STOP: begin
        if (cnt_r == BIT_LAST) begin
          cnt_s = CNT_ZERO;
          if (rx_sync_r == 1'b0) begin
            frame_err_s = 1'b1;
            state_s     = WAIT_IDLE;
          end else if (fifo.full) begin
            overrun_s = 1'b1;
            state_s   = IDLE;
          end else begin
            data_s  = shift_r;
            wr_en_s = 1'b1;
            state_s = IDLE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      // A held-low line (break) must go high before a new start bit counts.
      WAIT_IDLE: begin
        cnt_s = CNT_ZERO;
        if (rx_sync_r == 1'b1) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_IDLE;
        end
      end

      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
        idx_s   = IDX_ZERO;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames checked
// against a frame-level reference model (byte/stop/full -> expected event).
module tb_uart_rx;

  localparam int CPB     = 16;
  localparam int DB      = 8;
  localparam int LAT_EXP = 2 + 1 + CPB / 2 + (DB + 1) * CPB + 1;

  localparam int EV_WR  = 1;
  localparam int EV_OVR = 2;
  localparam int EV_FE  = 3;

  typedef struct {
    int         kind;
    logic [7:0] d;
    int         at;
  } ev_t;

  logic wr_clk = 1'b0;
  logic rst;
  logic rx;
  logic busy;
  logic frame_err;
  logic overrun;

  uart_rx_if #(.DATA_BITS(DB)) fifo_if ();

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .wr_clk    (wr_clk),
    .rst       (rst),
    .rx        (rx),
    .fifo      (fifo_if.master),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 wr_clk = ~wr_clk;

  int   n_checks  = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   multi_cnt = 0;
  ev_t  ev_q[$];
  ev_t  exp_q[$];
  logic [7:0] last_good = 8'h00;

  always @(posedge wr_clk) cyc <= cyc + 1;

  // Collect every status/write pulse, sampled away from the active edge.
  always @(negedge wr_clk) begin
    if ($countones({fifo_if.wr_en, frame_err, overrun}) > 1) multi_cnt <= multi_cnt + 1;
    if (fifo_if.wr_en === 1'b1) ev_q.push_back('{kind: EV_WR,  d: fifo_if.data, at: cyc});
    if (overrun === 1'b1)       ev_q.push_back('{kind: EV_OVR, d: fifo_if.data, at: cyc});
    if (frame_err === 1'b1)     ev_q.push_back('{kind: EV_FE,  d: fifo_if.data, at: cyc});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge wr_clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < DB; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop_v;
    idle(CPB);
    rx = 1'b1;
  endtask

  // Reference model: what one complete frame should produce.
  task automatic expect_frame(input logic [7:0] b, input logic stop_v, input logic full_v);
    if (!stop_v) begin
      exp_q.push_back('{kind: EV_FE, d: last_good, at: 0});
    end else if (full_v) begin
      exp_q.push_back('{kind: EV_OVR, d: last_good, at: 0});
    end else begin
      exp_q.push_back('{kind: EV_WR, d: b, at: 0});
      last_good = b;
    end
  endtask

  task automatic compare_events(input string tag);
    int n;
    check($sformatf("%s_count", tag), ev_q.size(), exp_q.size());
    n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_kind%0d", tag, i), ev_q[i].kind, exp_q[i].kind);
      check($sformatf("%s_data%0d", tag, i), {24'h0, ev_q[i].d}, {24'h0, exp_q[i].d});
    end
    ev_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int          s;
    int          lat;
    logic [7:0]  b;
    logic        stop_v;
    logic        full_v;

    rst          = 1'b1;
    rx           = 1'b1;
    fifo_if.full = 1'b0;
    idle(3);
    check("rst_data",  {24'h0, fifo_if.data}, 32'h0);
    check("rst_wr_en", {31'h0, fifo_if.wr_en}, 32'h0);
    check("rst_busy",  {31'h0, busy}, 32'h0);
    check("rst_fe",    {31'h0, frame_err}, 32'h0);
    check("rst_ovr",   {31'h0, overrun}, 32'h0);
    rst = 1'b0;
    idle(5);

    // 1: single byte with latency
    s = cyc;
    send_frame(8'hA5, 1'b1);
    expect_frame(8'hA5, 1'b1, 1'b0);
    idle(5);
    lat = (ev_q.size() > 0) ? ev_q[0].at - s : -1;
    check("t1_latency_in_window", {31'h0, (lat >= LAT_EXP - 1 && lat <= LAT_EXP + 1)}, 32'h1);
    compare_events("t1");

    // 2: back-to-back frames, single stop bit
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    expect_frame(8'h00, 1'b1, 1'b0);
    expect_frame(8'hFF, 1'b1, 1'b0);
    expect_frame(8'h55, 1'b1, 1'b0);
    idle(5);
    compare_events("t2");

    // 3: 4-cycle glitch while idle
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    check("t3_busy_during_glitch", {31'h0, busy}, 32'h1);
    idle(8);
    check("t3_busy_after_glitch", {31'h0, busy}, 32'h0);
    idle(4);
    send_frame(8'h3C, 1'b1);
    expect_frame(8'h3C, 1'b1, 1'b0);
    idle(5);
    compare_events("t3");

    // 4: framing error followed by a break
    send_frame(8'h81, 1'b0);
    rx = 1'b0;
    expect_frame(8'h81, 1'b0, 1'b0);
    idle(100);
    check("t4_busy_in_break", {31'h0, busy}, 32'h1);
    rx = 1'b1;
    idle(10);
    check("t4_busy_after_break", {31'h0, busy}, 32'h0);
    send_frame(8'h42, 1'b1);
    expect_frame(8'h42, 1'b1, 1'b0);
    idle(5);
    compare_events("t4");

    // 5: overrun while full, then normal reception
    fifo_if.full = 1'b1;
    send_frame(8'h7E, 1'b1);
    expect_frame(8'h7E, 1'b1, 1'b1);
    idle(5);
    check("t5_data_held", {24'h0, fifo_if.data}, {24'h0, last_good});
    compare_events("t5a");
    fifo_if.full = 1'b0;
    send_frame(8'h7E, 1'b1);
    expect_frame(8'h7E, 1'b1, 1'b0);
    idle(5);
    compare_events("t5b");

    // 6: reset in the middle of bit 3
    b  = 8'h99;
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = b[3];
    idle(CPB / 2);
    rst = 1'b1;
    #1;
    check("t6_busy_in_rst",  {31'h0, busy}, 32'h0);
    check("t6_data_in_rst",  {24'h0, fifo_if.data}, 32'h0);
    check("t6_wr_en_in_rst", {31'h0, fifo_if.wr_en}, 32'h0);
    check("t6_fe_in_rst",    {31'h0, frame_err}, 32'h0);
    check("t6_ovr_in_rst",   {31'h0, overrun}, 32'h0);
    last_good = 8'h00;
    idle(2);
    rst = 1'b0;
    rx  = 1'b1;
    idle(40);
    ev_q.delete();
    send_frame(8'h99, 1'b1);
    expect_frame(8'h99, 1'b1, 1'b0);
    idle(5);
    compare_events("t6");

    // Random frames: mixed bytes, stop errors and full
    for (int k = 0; k < 24; k++) begin
      b            = 8'($urandom_range(0, 255));
      stop_v       = ($urandom_range(0, 99) >= 15);
      full_v       = ($urandom_range(0, 3) == 0);
      fifo_if.full = full_v;
      send_frame(b, stop_v);
      expect_frame(b, stop_v, full_v);
      if (!stop_v) idle(CPB);
      else idle($urandom_range(0, 2));
    end
    fifo_if.full = 1'b0;
    idle(10);
    compare_events("rand");
    check("rand_data_final", {24'h0, fifo_if.data}, {24'h0, last_good});
    check("one_pulse_at_a_time", multi_cnt, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
